// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One request is in flight at a time; responses are routed back one-hot to the granted requester.
module alu_arbiter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [3:0]   req_op0,
   input  logic [3:0]   req_op1,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b1,
   output logic [3:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out,
   input  logic         alu_flag,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_flag,
   output logic         rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state_q;
   logic         ptr_q;
   logic         gnt_q;
   logic [3:0]   alu_op_q;
   logic [W-1:0] alu_a_q;
   logic [W-1:0] alu_b_q;
   logic [1:0]   rsp_valid_q;
   logic [W-1:0] rsp_data_q;
   logic         rsp_flag_q;
   logic         rsp_err_q;

   logic         gnt_d;
   logic [3:0]   sel_op;
   logic [W-1:0] sel_a;
   logic [W-1:0] sel_b;
   logic         accept;

   // The pointer's requester wins a tie; a lone valid requester always wins.
   always_comb begin
      gnt_d     = req_valid[ptr_q] ? ptr_q : ~ptr_q;
      sel_op    = gnt_d ? req_op1 : req_op0;
      sel_a     = gnt_d ? req_a1  : req_a0;
      sel_b     = gnt_d ? req_b1  : req_b0;
      accept    = (state_q == IDLE) && (|req_valid) && !rst;
      req_ready = '0;
      if (accept) req_ready[gnt_d] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         gnt_q       <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_flag_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  gnt_q <= gnt_d;
                  ptr_q <= ~gnt_d;
                  if (sel_op <= 4'd12) begin
                     alu_op_q <= sel_op;
                     alu_a_q  <= sel_a;
                     alu_b_q  <= sel_b;
                     state_q  <= EXEC;
                  end else begin
                     rsp_valid_q[gnt_d] <= 1'b1;
                     rsp_data_q         <= '0;
                     rsp_flag_q         <= 1'b0;
                     rsp_err_q          <= 1'b1;
                     state_q            <= RESP;
                  end
               end
            end
            EXEC: begin
               rsp_data_q         <= alu_out;
               rsp_flag_q         <= alu_flag;
               rsp_err_q          <= 1'b0;
               rsp_valid_q[gnt_q] <= 1'b1;
               alu_op_q           <= '0;
               alu_a_q            <= '0;
               alu_b_q            <= '0;
               state_q            <= RESP;
            end
            RESP: begin
               if (rsp_ready[gnt_q]) begin
                  rsp_valid_q <= '0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flag  = rsp_flag_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU model in the bench.
module tb_alu_arbiter;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   req_valid = '0;
   logic [1:0]   req_ready;
   logic [3:0]   req_op0 = '0, req_op1 = '0;
   logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic         alu_flag;
   logic [1:0]   rsp_valid;
   logic [1:0]   rsp_ready = '0;
   logic [W-1:0] rsp_data;
   logic         rsp_flag, rsp_err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   // ALU model: 0 = ADD, 1 = SUB, anything else = AND; flag = operands equal
   always_comb begin
      case (alu_op)
         4'd0:    alu_out = alu_a + alu_b;
         4'd1:    alu_out = alu_a - alu_b;
         default: alu_out = alu_a & alu_b;
      endcase
      alu_flag = (alu_a == alu_b);
   end

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err, alu_op, alu_a, alu_b} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got ready=%b rv=%b data=%h flag=%b err=%b op=%h a=%h b=%h, want all 0",
                  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_err, alu_op, alu_a, alu_b);
      end
      req_valid = '0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alternate();
      logic [1:0]   exp_g;
      logic [W-1:0] exp_d;
      req_op0 = 4'd0; req_a0 = 8'h01; req_b0 = 8'h01;
      req_op1 = 4'd1; req_a1 = 8'h09; req_b1 = 8'h04;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_d = (i % 2 == 0) ? 8'h02 : 8'h05;
         #1;
         n_cmp++;
         if (req_ready !== exp_g) begin
            n_bad++;
            $display("FAIL alt_grant[%0d]: got %b want %b", i, req_ready, exp_g);
         end
         tick();
         tick();
         n_cmp++;
         if (rsp_valid !== exp_g || rsp_data !== exp_d) begin
            n_bad++;
            $display("FAIL alt_rsp[%0d]: got rv=%b data=%h want rv=%b data=%h", i, rsp_valid, rsp_data, exp_g, exp_d);
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = '0;
   endtask

   task automatic test_single();
      req_op0 = 4'd0; req_a0 = 8'h05; req_b0 = 8'h03;
      req_valid = 2'b01;
      #1;
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_bad++;
         $display("FAIL single_ready: got %b want 01", req_ready);
      end
      tick();
      req_valid = '0;
      n_cmp++;
      if (alu_op !== 4'd0 || alu_a !== 8'h05 || alu_b !== 8'h03 || rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL single_exec: got op=%h a=%h b=%h rv=%b want 0/05/03/00", alu_op, alu_a, alu_b, rsp_valid);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_data !== 8'h08 || rsp_err !== 1'b0 || rsp_flag !== 1'b0 || alu_op !== 4'd0 || alu_a !== 8'h00) begin
         n_bad++;
         $display("FAIL single_rsp: got rv=%b data=%h err=%b flag=%b a=%h want 01/08/0/0/00", rsp_valid, rsp_data, rsp_err, rsp_flag, alu_a);
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = '0;
      n_cmp++;
      if (rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL single_done: got rv=%b want 00", rsp_valid);
      end
   endtask

   task automatic test_illegal();
      req_op1 = 4'hE; req_a1 = 8'h55; req_b1 = 8'h66;
      req_valid = 2'b10;
      #1;
      n_cmp++;
      if (req_ready !== 2'b10) begin
         n_bad++;
         $display("FAIL illegal_ready: got %b want 10", req_ready);
      end
      tick();
      req_valid = '0;
      n_cmp++;
      if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_data !== 8'h00 || rsp_flag !== 1'b0 ||
          alu_op !== 4'd0 || alu_a !== 8'h00 || alu_b !== 8'h00) begin
         n_bad++;
         $display("FAIL illegal_rsp: got rv=%b err=%b data=%h flag=%b op=%h a=%h b=%h want 10/1/00/0/0/00/00",
                  rsp_valid, rsp_err, rsp_data, rsp_flag, alu_op, alu_a, alu_b);
      end
      rsp_ready = 2'b01;
      tick();
      n_cmp++;
      if (rsp_valid !== 2'b10) begin
         n_bad++;
         $display("FAIL illegal_wrong_ready: got rv=%b want 10", rsp_valid);
      end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = '0;
      n_cmp++;
      if (rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL illegal_done: got rv=%b want 00", rsp_valid);
      end
   endtask

   task automatic test_stall();
      req_op0 = 4'd9; req_a0 = 8'h2A; req_b0 = 8'h2A;
      req_valid = 2'b01;
      #1;
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_bad++;
         $display("FAIL stall_ready: got %b want 01", req_ready);
      end
      tick();
      req_valid = 2'b11;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 2'b01 || rsp_flag !== 1'b1 || rsp_data !== 8'h2A || req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: got rv=%b flag=%b data=%h ready=%b want 01/1/2a/00",
                     i, rsp_valid, rsp_flag, rsp_data, req_ready);
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 2'b01;
      tick();
      rsp_ready = '0;
      n_cmp++;
      if (rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL stall_done: got rv=%b want 00", rsp_valid);
      end
   endtask

   task automatic test_reset_in_flight();
      int unsigned stray;
      req_op0 = 4'd1; req_a0 = 8'h10; req_b0 = 8'h03;
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      n_cmp++;
      if (alu_op !== 4'd1 || alu_a !== 8'h10) begin
         n_bad++;
         $display("FAIL rif_exec: got op=%h a=%h want 1/10", alu_op, alu_a);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_data, rsp_flag, rsp_err, alu_op, alu_a, alu_b, req_ready} !== '0) begin
         n_bad++;
         $display("FAIL rif_clear: got rv=%b data=%h op=%h a=%h b=%h ready=%b want all 0",
                  rsp_valid, rsp_data, alu_op, alu_a, alu_b, req_ready);
      end
      tick();
      rst = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid !== 2'b00) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++;
         $display("FAIL rif_no_rsp: got %0d cycles with rsp_valid, want 0", stray);
      end
      req_op0 = 4'd0; req_a0 = 8'h02; req_b0 = 8'h02;
      req_op1 = 4'd0; req_a1 = 8'h07; req_b1 = 8'h07;
      req_valid = 2'b11;
      #1;
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_bad++;
         $display("FAIL rif_ptr: got %b want 01", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_data !== 8'h04) begin
         n_bad++;
         $display("FAIL rif_next: got rv=%b data=%h want 01/04", rsp_valid, rsp_data);
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_alternate();
      test_single();
      test_illegal();
      test_stall();
      test_reset_in_flight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter W, default 8, operand/result width in bits.
REQ-002: Clk  input  1  system clock; all state updates on rising edge.
REQ-003: Reset  input  1  asynchronous, active-high reset.
REQ-004: req_valid  input  2  per-requester request valid; index 0 = requester 0.
REQ-005: req_ready  output  2  per-requester acceptance; a request transfers when req_valid[i] and req_ready[i] are both high on an edge.
REQ-006: req_op0, req_op1  input  4  op_mne code per requester (ADD=0 ... TAPGET=12).
REQ-007: req_a0, req_b0, req_a1, req_b1  input  W  operands per requester.
REQ-008: alu_op  output  4  op_mne code driven to the shared ALU.
REQ-009: alu_a, alu_b  output  W  operands driven to the shared ALU.
REQ-010: alu_out  input  W  combinational ALU result for the current alu_op/alu_a/alu_b.
REQ-011: alu_flag  input  1  combinational ALU condition flag (branch-taken for BGE/BNE/BEQ, zero otherwise).
REQ-012: rsp_valid  output  2  one-hot response valid toward the granted requester.
REQ-013: rsp_ready  input  2  per-requester response acceptance.
REQ-014: rsp_data  output  W  captured ALU result.
REQ-015: rsp_flag  output  1  captured alu_flag.
REQ-016: rsp_err  output  1  high when the response is for an illegal opcode (13-15).

Function
REQ-017: FSM states IDLE, EXEC, RESP; exactly one request is in flight at a time.
REQ-018: In IDLE, req_ready is one-hot toward the arbitration winner among asserted req_valid bits, and 0 when no req_valid bit is asserted; req_ready is 0 in EXEC and RESP.
REQ-019: Arbitration is round-robin: a 1-bit priority pointer names the preferred requester; with both valid, the pointer's requester wins; with one valid, that requester wins regardless of the pointer.
REQ-020: After each accepted request, the pointer is set to the requester that was not granted.
REQ-021: On acceptance, op, operands and grant index are registered; the next state is EXEC for legal ops (0-12) and RESP for illegal ops (13-15).
REQ-022: In EXEC, alu_op/alu_a/alu_b present the registered values for exactly one cycle; at the end of EXEC, alu_out and alu_flag are captured into rsp_data/rsp_flag, rsp_err is set to 0, and the next state is RESP.
REQ-023: For an illegal op, the ALU is not driven (alu_op/alu_a/alu_b hold 0); rsp_data=0, rsp_flag=0, rsp_err=1.
REQ-024: In RESP, rsp_valid[grant]=1 and rsp_data/rsp_flag/rsp_err are held stable until rsp_ready[grant] is high on an edge; that edge returns the FSM to IDLE. rsp_ready on the non-granted index is ignored.
REQ-025: Latency for a legal op is: accept on edge N, EXEC during cycle N+1, rsp_valid high in cycle N+2; minimum issue interval is 3 cycles.
REQ-026: A new request can be accepted only in IDLE, which is reached on the edge following response acceptance; there is no back-to-back bypass.
REQ-027: Outside EXEC, alu_op/alu_a/alu_b drive 0.

Reset
REQ-028: While Reset is high, state=IDLE, pointer=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_err=0, alu_op=0, alu_a=0, alu_b=0.
REQ-029: Reset asserted in EXEC or RESP discards the in-flight request; no response is ever produced for it.

Verification
REQ-030: Single request, requester 0, ADD a=8'h05 b=8'h03; the ALU model returns 8'h08 -> rsp_valid=2'b01 two cycles after acceptance, rsp_data=8'h08, rsp_err=0.
REQ-031: Both requesters are valid continuously after reset -> grants alternate 0,1,0,1; each response is routed only to its own rsp_valid bit.
REQ-032: Requester 1 issues op 4'hE -> EXEC is skipped; rsp_valid=2'b10 one cycle after acceptance with rsp_err=1 and rsp_data=0; the ALU is never driven.
REQ-033: Requester 0 issues BEQ a=b=8'h2A with the model returning flag=1, and rsp_ready is held low for 5 cycles -> rsp_valid, rsp_flag=1 and rsp_data stay stable; req_ready stays 0 throughout.
REQ-034: Reset is pulsed during EXEC of a SUB -> all outputs return to 0 immediately; no rsp_valid follows, and the next request is accepted normally from IDLE with pointer=0.
